// File: rtl/klingon_pkg.sv
// Shared constants for the Klingon seven-segment scan display.
// Segment order is A..G with A in bit 6 and G in bit 0.
package klingon_pkg;

   localparam logic [6:0] SEG_OFF = 7'b000_0000;

   localparam logic [6:0] KLINGON_GLYPH [0:9] = '{
      7'h5B,
      7'h30,
      7'h6D,
      7'h79,
      7'h33,
      7'h5E,
      7'h1F,
      7'h72,
      7'h7F,
      7'h67
   };

endpackage

// File: rtl/klingon_seg_decode.sv
// Combinational glyph decoder: one 4-bit code plus a blank flag to active-high segments.
module klingon_seg_decode
   import klingon_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (!blank && (code <= 4'd9)) begin
         seg = KLINGON_GLYPH[code];
      end
   end

endmodule

// File: rtl/klingon_scan_display.sv
// Multiplexed Klingon-glyph display scanner with a shadow register that commits
// only at frame boundaries, so a frame is never shown half old and half new.
module klingon_scan_display
   import klingon_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    load_ack,
   output logic                    code_err
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Pin-level values; the polarity inversion is folded into the registers.
   localparam logic [6:0]            SEG_PIN_OFF = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_PIN_RST  =
      NUM_DIGITS'(1) ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};

   logic [CNT_W-1:0]        cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [4*NUM_DIGITS-1:0] shadow_code_q;
   logic [NUM_DIGITS-1:0]   shadow_blank_q;
   logic                    pend_q;
   logic [4*NUM_DIGITS-1:0] disp_code_q;
   logic [NUM_DIGITS-1:0]   disp_blank_q;
   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic                    ack_q;
   logic                    err_q;

   logic                    tick;
   logic                    frame_end;
   logic                    commit;
   logic [IDX_W-1:0]        idx_next;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [4*NUM_DIGITS-1:0] src_code;
   logic [NUM_DIGITS-1:0]   src_blank;
   logic [3:0]              dec_code;
   logic                    dec_blank;
   logic [6:0]              dec_seg;
   logic                    shadow_bad;

   always_comb begin
      tick      = (cnt_q == CNT_LAST);
      frame_end = tick && (idx_q == IDX_LAST);
      commit    = frame_end && pend_q;
      idx_next  = frame_end ? '0 : idx_q + 1'b1;
      an_next   = NUM_DIGITS'(1) << idx_next;
   end

   // On a commit edge the first digit of the new frame must already come from
   // the shadow, otherwise seg would lag an by one dwell.
   always_comb begin
      src_code  = commit ? shadow_code_q : disp_code_q;
      src_blank = commit ? shadow_blank_q : disp_blank_q;
      dec_code  = src_code[4*idx_next +: 4];
      dec_blank = src_blank[idx_next];
   end

   always_comb begin
      shadow_bad = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (!shadow_blank_q[i] && (shadow_code_q[4*i +: 4] > 4'd9)) begin
            shadow_bad = 1'b1;
         end
      end
   end

   klingon_seg_decode u_decode (
      .code  (dec_code),
      .blank (dec_blank),
      .seg   (dec_seg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         idx_q          <= '0;
         shadow_code_q  <= '0;
         shadow_blank_q <= '1;
         pend_q         <= 1'b0;
         disp_code_q    <= '0;
         disp_blank_q   <= '1;
         seg_q          <= SEG_PIN_OFF;
         an_q           <= AN_PIN_RST;
         ack_q          <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
         ack_q <= commit;

         // A load on the commit edge refills the shadow and stays pending.
         if (load) begin
            shadow_code_q  <= digits_in;
            shadow_blank_q <= blank_mask;
            pend_q         <= 1'b1;
         end else if (commit) begin
            pend_q <= 1'b0;
         end

         if (commit) begin
            disp_code_q  <= shadow_code_q;
            disp_blank_q <= shadow_blank_q;
            if (shadow_bad) begin
               err_q <= 1'b1;
            end
         end

         if (tick) begin
            idx_q <= idx_next;
            an_q  <= an_next ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
            seg_q <= dec_seg ^ {7{SEG_ACTIVE_LOW}};
         end
      end
   end

   assign seg      = seg_q;
   assign an       = an_q;
   assign load_ack = ack_q;
   assign code_err = err_q;

endmodule

// File: tb/tb_klingon_scan_display.sv
// Scoreboard bench: a frame-level reference model predicts commits and digit
// timing from edge counts; a monitor pops expectations on each load_ack.
module tb_klingon_scan_display;
   import klingon_pkg::*;

   localparam int N     = 4;
   localparam int D     = 4;
   localparam int FRAME = N * D;
   localparam int D2    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  mask;

   logic [6:0] seg, seg_p0, seg_p1;
   logic [3:0] an;
   logic       an_p0, an_p1;
   logic       ack, ack_p0, ack_p1;
   logic       err, err_p0, err_p1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   klingon_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .reset(reset), .load(load), .digits_in(digits), .blank_mask(mask),
      .seg(seg), .an(an), .load_ack(ack), .code_err(err)
   );

   klingon_scan_display #(.NUM_DIGITS(1), .SCAN_DIV(D2), .SEG_ACTIVE_LOW(1'b0)) dut_p0 (
      .clk(clk), .reset(reset), .load(load), .digits_in(digits[3:0]), .blank_mask(mask[0]),
      .seg(seg_p0), .an(an_p0), .load_ack(ack_p0), .code_err(err_p0)
   );

   klingon_scan_display #(.NUM_DIGITS(1), .SCAN_DIV(D2), .SEG_ACTIVE_LOW(1'b1)) dut_p1 (
      .clk(clk), .reset(reset), .load(load), .digits_in(digits[3:0]), .blank_mask(mask[0]),
      .seg(seg_p1), .an(an_p1), .load_ack(ack_p1), .code_err(err_p1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] c, input logic b);
      if (b || c > 4'd9) return SEG_OFF;
      return KLINGON_GLYPH[c];
   endfunction

   function automatic logic any_bad(input logic [15:0] c, input logic [3:0] m);
      for (int i = 0; i < N; i++) begin
         if (!m[i] && c[4*i +: 4] > 4'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Reference model, main instance: edges since reset decide index and frame boundaries.
   typedef struct {
      logic [6:0] seg0;
      logic       err;
   } ack_t;
   ack_t ack_sb[$];

   int unsigned k         = 0;
   logic        pend      = 1'b0;
   logic [15:0] sh_code   = '0;
   logic [3:0]  sh_mask   = '1;
   logic [15:0] disp_code = '0;
   logic [3:0]  disp_mask = '1;
   logic        exp_err   = 1'b0;
   logic        exp_ack   = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         k = 0; pend = 1'b0; disp_code = '0; disp_mask = '1; exp_err = 1'b0; exp_ack = 1'b0;
      end else begin
         k++;
         exp_ack = pend && (k % FRAME == 0);
         if (exp_ack) begin
            disp_code = sh_code;
            disp_mask = sh_mask;
            if (any_bad(sh_code, sh_mask)) exp_err = 1'b1;
            ack_sb.push_back('{glyph(disp_code[3:0], disp_mask[0]), exp_err});
         end
         if (load) begin
            sh_code = digits; sh_mask = mask; pend = 1'b1;
         end else if (exp_ack) begin
            pend = 1'b0;
         end
      end
   end

   // Reference model, single-digit polarity instances.
   int unsigned k2         = 0;
   logic        pend2      = 1'b0;
   logic [3:0]  sh2_code   = '0;
   logic        sh2_mask   = 1'b1;
   logic [3:0]  disp2_code = '0;
   logic        disp2_mask = 1'b1;
   logic        exp2_err   = 1'b0;
   logic        exp2_ack   = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         k2 = 0; pend2 = 1'b0; disp2_code = '0; disp2_mask = 1'b1;
         exp2_err = 1'b0; exp2_ack = 1'b0;
      end else begin
         k2++;
         exp2_ack = pend2 && (k2 % D2 == 0);
         if (exp2_ack) begin
            disp2_code = sh2_code;
            disp2_mask = sh2_mask;
            if (!sh2_mask && sh2_code > 4'd9) exp2_err = 1'b1;
         end
         if (load) begin
            sh2_code = digits[3:0]; sh2_mask = mask[0]; pend2 = 1'b1;
         end else if (exp2_ack) begin
            pend2 = 1'b0;
         end
      end
   end

   // Cycle checker: every output against the model, away from the active edge.
   always @(negedge clk) begin
      int i;
      i = (k / D) % N;
      check("an", an, 32'(1) << i);
      check("seg", seg, glyph(disp_code[4*i +: 4], disp_mask[i]));
      check("load_ack", ack, exp_ack && !reset);
      check("code_err", err, exp_err);
      check("pol_an_hi", an_p0, 1);
      check("pol_an_lo", an_p1, 0);
      check("pol_seg", seg_p0, glyph(disp2_code, disp2_mask));
      check("pol_inverse", seg_p0 ^ seg_p1, 7'h7F);
      check("pol_ack", {ack_p1, ack_p0}, {2{exp2_ack && !reset}});
      check("pol_err", {err_p1, err_p0}, {2{exp2_err}});
   end

   // Scoreboard monitor: pops one expectation per observed load_ack.
   always @(negedge clk) begin
      ack_t e;
      if (ack) begin
         if (ack_sb.size() == 0) begin
            check("ack_unexpected", 1, 0);
         end else begin
            e = ack_sb.pop_front();
            check("ack_an", an, 4'b0001);
            check("ack_seg0", seg, e.seg0);
            check("ack_err", err, e.err);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      load = 1'b0;
      #1;
      check("rst_an", an, 4'b0001);
      check("rst_seg", seg, SEG_OFF);
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_pol", {an_p1, seg_p1}, {1'b0, ~SEG_OFF});
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] c, input logic [3:0] m);
      @(negedge clk);
      load = 1'b1; digits = c; mask = m;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Returns at the negedge where the model edge count reaches the wanted phase.
   task automatic wait_phase(input int p);
      for (int n = 0; n < 2 * FRAME; n++) begin
         @(negedge clk);
         if (k % FRAME == p) return;
      end
      check("wait_phase_timeout", 0, 1);
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      for (int i = 0; i < N; i++) begin
         v[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; digits = '0; mask = '0;
      do_reset();

      // Basic scan and first commit at the frame wrap.
      do_load(16'h3210, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);

      // Double load before the boundary: only the second one shows.
      wait_phase(2);
      do_load(16'h1111, 4'b0000);
      do_load(16'h2222, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);

      // Load coinciding with the commit edge.
      wait_phase(4);
      do_load(16'h5555, 4'b0000);
      wait_phase(15);
      load = 1'b1; digits = 16'h6666; mask = 4'b0000;
      @(negedge clk);
      load = 1'b0;
      repeat (2 * FRAME + 2) @(negedge clk);

      // Masked invalid code, then an unmasked one sets the sticky error.
      do_load(16'h00C9, 4'b0010);
      repeat (2 * FRAME) @(negedge clk);
      check("err_masked", err, 0);
      do_load(16'h000C, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);
      check("err_set", err, 1);
      do_load(16'h4321, 4'b0000);
      repeat (2 * FRAME) @(negedge clk);
      check("err_sticky", err, 1);

      // Reset with a load pending mid-dwell.
      wait_phase(3);
      do_load(16'h7777, 4'b0000);
      do_reset();
      repeat (2 * FRAME) @(negedge clk);
      check("post_rst_blank", seg, SEG_OFF);
      do_load(16'h9876, 4'b0100);
      repeat (2 * FRAME) @(negedge clk);

      // Randomized loads with occasional resets.
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         if ($urandom_range(0, 14) == 0) begin
            do_reset();
         end else begin
            do_load(rand_digits(), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
         end
      end
      repeat (3 * FRAME) @(negedge clk);

      check("ack_missing", ack_sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
